// File: rtl/note_period_detector_pkg.sv
// Shared types, widths and default tuning for the note period detector.
package note_detect_pkg;

    localparam int unsigned PERIOD_W = 20;
    localparam int unsigned HALF_W   = 19;
    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned MATCH_W  = 3;
    localparam int unsigned MATCH_EW = MATCH_W + 1;

    localparam logic [SAMPLE_W-1:0] THRESH_DEF     = 32'd2000000;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD_DEF = 20'd5000;
    localparam logic [PERIOD_W-1:0] MAX_PERIOD_DEF = 20'd1000000;
    localparam logic [PERIOD_W-1:0] TOL_DEF        = 20'd64;
    localparam logic [MATCH_W-1:0]  LOCK_COUNT_DEF = 3'd2;

    typedef enum logic [1:0] {
        UNKNOWN,
        POS,
        NEG
    } pol_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOCKED
    } lock_state_t;

    // Unsigned distance between two periods, always larger minus smaller.
    function automatic logic [PERIOD_W-1:0] period_diff(
        input logic [PERIOD_W-1:0] a,
        input logic [PERIOD_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/note_period_detector_zero_cross_slicer.sv
// Hysteresis polarity slicer; flags a rising crossing in the cycle the
// qualifying sample arrives.
module zero_cross_slicer
    import note_detect_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] THRESH = THRESH_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_rise_xing_c
);

    localparam logic signed [SAMPLE_W-1:0] THRESH_POS = THRESH;
    localparam logic signed [SAMPLE_W-1:0] THRESH_NEG = -THRESH_POS;

    pol_t r_pol;
    logic w_at_pos;
    logic w_at_neg;

    assign w_at_pos = $signed(i_sample) >= THRESH_POS;
    assign w_at_neg = $signed(i_sample) <= THRESH_NEG;

    // Leaving UNKNOWN towards POS is not a crossing; only NEG -> POS counts.
    assign o_rise_xing_c = i_sample_valid && (r_pol == NEG) && w_at_pos;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pol <= UNKNOWN;
        end else if (i_sample_valid) begin
            if (w_at_pos) begin
                r_pol <= POS;
            end else if (w_at_neg) begin
                r_pol <= NEG;
            end
        end
    end

endmodule

// File: rtl/note_period_detector.sv
// Measures the full period of incoming audio between rising crossings and
// reports a stable pitch as a half-period delay once it has locked.
module note_period_detector
    import note_detect_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] THRESH     = THRESH_DEF,
    parameter logic [PERIOD_W-1:0] MIN_PERIOD = MIN_PERIOD_DEF,
    parameter logic [PERIOD_W-1:0] MAX_PERIOD = MAX_PERIOD_DEF,
    parameter logic [PERIOD_W-1:0] TOL        = TOL_DEF,
    parameter logic [MATCH_W-1:0]  LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [HALF_W-1:0]   half_period,
    output logic                period_valid,
    output logic                locked
);

    lock_state_t         r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_prev;
    logic                r_prev_valid;
    logic [MATCH_W-1:0]  r_match;
    logic [HALF_W-1:0]   r_half;
    logic                r_period_valid;
    logic                r_locked;

    lock_state_t         w_state_nxt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic [PERIOD_W-1:0] w_prev_nxt;
    logic                w_prev_valid_nxt;
    logic [MATCH_W-1:0]  w_match_nxt;
    logic [HALF_W-1:0]   w_half_nxt;
    logic                w_period_valid_nxt;

    logic                w_rise_xing;
    logic                w_armed;
    logic                w_in_range;
    logic                w_close;
    logic [MATCH_EW-1:0] w_match_inc;
    logic [MATCH_W-1:0]  w_match_sat;

    zero_cross_slicer #(
        .THRESH (THRESH)
    ) u_slicer (
        .i_clk          (CLOCK_50),
        .i_rst          (reset),
        .i_sample_valid (sample_valid),
        .i_sample       (sample),
        .o_rise_xing_c  (w_rise_xing)
    );

    // In a crossing cycle r_cnt already holds the distance to the previous one.
    assign w_armed     = (r_state != ST_IDLE);
    assign w_in_range  = (r_cnt >= MIN_PERIOD) && (r_cnt < MAX_PERIOD);
    assign w_close     = (period_diff(r_cnt, r_prev) <= TOL);
    assign w_match_inc = {1'b0, r_match} + MATCH_EW'(1);
    assign w_match_sat = (w_match_inc >= {1'b0, LOCK_COUNT}) ? LOCK_COUNT
                                                              : w_match_inc[MATCH_W-1:0];

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_prev_nxt         = r_prev;
        w_prev_valid_nxt   = r_prev_valid;
        w_match_nxt        = r_match;
        w_half_nxt         = r_half;
        w_period_valid_nxt = 1'b0;

        if (w_rise_xing) begin
            w_cnt_nxt = PERIOD_W'(1);
        end else if (w_armed && (r_cnt < MAX_PERIOD)) begin
            w_cnt_nxt = r_cnt + PERIOD_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_rise_xing) begin
                    w_state_nxt = ST_ARMED;
                end
            end

            ST_ARMED, ST_LOCKED: begin
                if (w_rise_xing) begin
                    if (!w_in_range) begin
                        w_prev_valid_nxt = 1'b0;
                        w_match_nxt      = '0;
                        w_state_nxt      = ST_ARMED;
                    end else if (!r_prev_valid) begin
                        w_prev_nxt       = r_cnt;
                        w_prev_valid_nxt = 1'b1;
                        w_match_nxt      = '0;
                    end else if (w_close) begin
                        w_prev_nxt  = r_cnt;
                        w_match_nxt = w_match_sat;
                        if (w_match_sat == LOCK_COUNT) begin
                            w_state_nxt        = ST_LOCKED;
                            w_half_nxt         = r_cnt[PERIOD_W-1:1];
                            w_period_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_prev_nxt  = r_cnt;
                        w_match_nxt = '0;
                        w_state_nxt = ST_ARMED;
                    end
                end else if (r_cnt == MAX_PERIOD) begin
                    // Silence for a whole max period: drop lock, wait for a fresh arm.
                    w_state_nxt      = ST_IDLE;
                    w_prev_valid_nxt = 1'b0;
                    w_match_nxt      = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_prev         <= '0;
            r_prev_valid   <= 1'b0;
            r_match        <= '0;
            r_half         <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_prev         <= w_prev_nxt;
            r_prev_valid   <= w_prev_valid_nxt;
            r_match        <= w_match_nxt;
            r_half         <= w_half_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_locked       <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign half_period  = r_half;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;

endmodule
